// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master transaction engine among N requesters.
module i2c_txn_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     req_rw,
    input  logic [8*N-1:0]   req_reg,
    input  logic [8*N-1:0]   req_wdata,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic             rsp_nack,
    output logic             rsp_timeout,
    output logic             m_start,
    output logic             m_rw,
    output logic [7:0]       m_reg,
    output logic [7:0]       m_wdata,
    output logic             m_abort,
    input  logic             m_busy,
    input  logic             m_done,
    input  logic             m_nack,
    input  logic [7:0]       m_rdata
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            m_rw_q, m_rw_d;
    logic [7:0]      m_reg_q, m_reg_d;
    logic [7:0]      m_wdata_q, m_wdata_d;
    logic [N-1:0]    rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic            rsp_nack_q, rsp_nack_d;
    logic            rsp_timeout_q, rsp_timeout_d;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic            tmo_hit;

    // First asserted request at or after the pointer, wrapping N-1 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!pick_found && req[(int'(ptr_q) + i) % int'(N)]) begin
                pick_found = 1'b1;
                pick_idx   = PW'((int'(ptr_q) + i) % int'(N));
            end
        end
    end

    assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Engine handshake strobes are decoded from state so start never overlaps busy.
    assign m_start = (state_q == S_ISSUE) && !m_busy;
    assign m_abort = (state_q == S_WAIT) && !m_done && tmo_hit;

    // Next-state and registered output computation.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        gnt_d         = gnt_q;
        cnt_d         = cnt_q;
        m_rw_d        = m_rw_q;
        m_reg_d       = m_reg_q;
        m_wdata_d     = m_wdata_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_nack_d    = rsp_nack_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    win_d     = pick_idx;
                    gnt_d     = N'(1) << pick_idx;
                    m_rw_d    = req_rw[pick_idx];
                    m_reg_d   = req_reg[8*pick_idx +: 8];
                    m_wdata_d = req_wdata[8*pick_idx +: 8];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!m_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (m_done) begin
                    rsp_valid_d   = gnt_q;
                    rsp_rdata_d   = (m_rw_q && !m_nack) ? m_rdata : 8'h00;
                    rsp_nack_d    = m_nack;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (tmo_hit) begin
                    rsp_valid_d   = gnt_q;
                    rsp_rdata_d   = 8'h00;
                    rsp_nack_d    = 1'b0;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                gnt_d   = '0;
                ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            gnt_q         <= '0;
            cnt_q         <= '0;
            m_rw_q        <= 1'b0;
            m_reg_q       <= 8'h00;
            m_wdata_q     <= 8'h00;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= 8'h00;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            gnt_q         <= gnt_d;
            cnt_q         <= cnt_d;
            m_rw_q        <= m_rw_d;
            m_reg_q       <= m_reg_d;
            m_wdata_q     <= m_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_nack_q    <= rsp_nack_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_nack    = rsp_nack_q;
    assign rsp_timeout = rsp_timeout_q;
    assign m_rw        = m_rw_q;
    assign m_reg       = m_reg_q;
    assign m_wdata     = m_wdata_q;

endmodule
